load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: CPU load/store to Wishbone classic master with alignment checks,
// retry/backoff, timeout abort and load data extension.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic [31:0] rdata_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  typedef enum logic [1:0] {IDLE, ACCESS, BACKOFF} state_t;
  state_t        r_state;
  logic [TW-1:0] r_tmo;
  logic [RW-1:0] r_rty;
  logic [1:0]    r_size, r_off, r_cause;
  logic          r_uns, r_done, r_fault, r_cyc, r_stb, r_we;
  logic [31:0]   r_rdata, r_adr, r_dat;
  logic [3:0]    r_sel;
  logic          w_misaligned, w_tmo_hit, w_rty_abort, w_term, w_fail;
  logic [3:0]    w_sel;
  logic [31:0]   w_dat, w_shift, w_load;
  logic [RW-1:0] w_rty_next;
  logic [1:0]    w_cause;
  always_comb begin
    w_misaligned = (size_i == 2'b11) | ((size_i == 2'b01) & addr_i[0]) |
                   ((size_i == 2'b10) & (|addr_i[1:0]));
    w_sel = (size_i == 2'b00) ? 4'b0001 << addr_i[1:0] :
            (size_i == 2'b01) ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_dat = (size_i == 2'b00) ? {4{wdata_i[7:0]}} :
            (size_i == 2'b01) ? {2{wdata_i[15:0]}} : wdata_i;
    w_shift = dat_i >> {r_off, 3'b000};
    w_load = (r_size == 2'b00) ? {{24{~r_uns & w_shift[7]}}, w_shift[7:0]} :
             (r_size == 2'b01) ? {{16{~r_uns & w_shift[15]}}, w_shift[15:0]} : w_shift;
    // Retry counter saturates at MAX_RETRIES+1, the first value that aborts.
    w_rty_next = (r_rty == RW'(MAX_RETRIES + 1)) ? r_rty : r_rty + 1'b1;
    w_rty_abort = w_rty_next > RW'(MAX_RETRIES);
    w_tmo_hit = r_tmo == TW'(TIMEOUT_CYCLES - 1);
    w_term = err_i | ack_i | (rty_i ? w_rty_abort : w_tmo_hit);
    w_fail = err_i | ~ack_i;
    w_cause = err_i ? 2'b10 : ack_i ? 2'b00 : 2'b11;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_tmo <= '0;
      r_rty <= '0;
      r_size <= '0;
      r_off <= '0;
      r_uns <= 1'b0;
      r_done <= 1'b0;
      r_fault <= 1'b0;
      r_cause <= '0;
      r_rdata <= '0;
      r_cyc <= 1'b0;
      r_stb <= 1'b0;
      r_we <= 1'b0;
      r_adr <= '0;
      r_sel <= '0;
      r_dat <= '0;
    end else begin
      r_done <= 1'b0;
      r_fault <= 1'b0;
      r_cause <= '0;
      case (r_state)
        IDLE: if (req_i) begin
          if (w_misaligned) begin
            r_done <= 1'b1;
            r_fault <= 1'b1;
            r_cause <= 2'b01;
          end else begin
            r_state <= ACCESS;
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we <= we_i;
            r_adr <= {addr_i[31:2], 2'b00};
            r_sel <= w_sel;
            r_dat <= w_dat;
            r_size <= size_i;
            r_off <= addr_i[1:0];
            r_uns <= unsigned_i;
            r_tmo <= '0;
            r_rty <= '0;
          end
        end
        ACCESS: if (w_term) begin
          r_state <= IDLE;
          r_cyc <= 1'b0;
          r_stb <= 1'b0;
          r_done <= 1'b1;
          r_fault <= w_fail;
          r_cause <= w_cause;
          r_rdata <= w_fail ? 32'h0 : (r_we ? r_rdata : w_load);
          if (rty_i) r_rty <= w_rty_next;
        end else if (rty_i) begin
          r_state <= BACKOFF;
          r_cyc <= 1'b0;
          r_stb <= 1'b0;
          r_rty <= w_rty_next;
        end else r_tmo <= r_tmo + 1'b1;
        default: begin
          r_state <= ACCESS;
          r_cyc <= 1'b1;
          r_stb <= 1'b1;
          r_tmo <= '0;
        end
      endcase
    end
  end
  assign ready_o = r_state == IDLE;
  assign done_o = r_done;
  assign fault_o = r_fault;
  assign fault_cause_o = r_cause;
  assign rdata_o = r_rdata;
  assign cyc_o = r_cyc;
  assign stb_o = r_stb;
  assign we_o = r_we;
  assign adr_o = r_adr;
  assign sel_o = r_sel;
  assign dat_o = r_dat;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a small Wishbone slave model
// (memory, silent, error, or retry-then-ack).
module tb_load_store_unit;
  logic        clk = 0, rst = 1, req = 0, we = 0, uns = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr = 0, wdata = 0, dat_i = 0;
  logic        ack = 0, err = 0, rty = 0;
  logic        ready_o, done_o, fault_o, cyc_o, stb_o, we_o;
  logic [1:0]  fault_cause_o;
  logic [31:0] rdata_o, adr_o, dat_o;
  logic [3:0]  sel_o;
  int checks = 0, failures = 0;
  int mode = 0, rty_left = 0;
  int lat, ncyc, gaps, ndone;
  logic pcyc;
  logic [3:0]  seen_sel;
  logic [31:0] seen_dat;
  logic [31:0] mem [16];
  load_store_unit #(.TIMEOUT_CYCLES(8), .MAX_RETRIES(3)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata), .ready_o(ready_o),
    .done_o(done_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o),
    .rdata_o(rdata_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_i),
    .ack_i(ack), .err_i(err), .rty_i(rty)
  );
  always #5 clk = ~clk;
  // Registered slave: answers one cycle after seeing a strobe.
  always @(posedge clk) begin
    ack <= 0;
    err <= 0;
    rty <= 0;
    if (cyc_o && stb_o && !ack && !err && !rty) begin
      if (mode == 3) err <= 1;
      else if (mode == 2 && rty_left > 0) begin
        rty <= 1;
        rty_left <= rty_left - 1;
      end else if (mode != 1) begin
        ack <= 1;
        if (we_o) begin
          for (int b = 0; b < 4; b++)
            if (sel_o[b]) mem[adr_o[5:2]][8*b +: 8] <= dat_o[8*b +: 8];
        end else dat_i <= mem[adr_o[5:2]];
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run(input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req = 1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    ncyc = 0; gaps = 0; pcyc = 0; seen_sel = 0; seen_dat = 0;
    @(negedge clk);
    req = 0;
    lat = 1;
    while (!done_o && lat < 100) begin
      if (cyc_o) begin
        ncyc++;
        seen_sel = sel_o;
        seen_dat = dat_o;
      end
      if (pcyc && !cyc_o) gaps++;
      pcyc = cyc_o;
      @(negedge clk);
      lat++;
    end
    chk("done_seen", done_o, 1);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_o, 1);
    chk("rst_cyc", cyc_o, 0);
    chk("rst_sel", sel_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_done", done_o, 0);
    rst = 0;
    run(1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    chk("sw_sel", seen_sel, 4'b1111);
    chk("sw_fault", fault_o, 0);
    run(0, 2'b00, 0, 32'h13, 0);
    chk("lb_sel", seen_sel, 4'b1000);
    chk("lb_data", rdata_o, 32'hFFFFFFDE);
    chk("lb_lat", lat, 3);
    chk("lb_ready", ready_o, 1);
    run(1, 2'b10, 0, 32'h10, 32'h80017F00);
    run(0, 2'b01, 1, 32'h12, 0);
    chk("lhu_sel", seen_sel, 4'b1100);
    chk("lhu_data", rdata_o, 32'h00008001);
    run(0, 2'b01, 0, 32'h12, 0);
    chk("lh_data", rdata_o, 32'hFFFF8001);
    run(0, 2'b00, 1, 32'h11, 0);
    chk("lbu_data", rdata_o, 32'h0000007F);
    run(1, 2'b00, 0, 32'h11, 32'h000000AB);
    chk("sb_sel", seen_sel, 4'b0010);
    chk("sb_dat", seen_dat, 32'hABABABAB);
    chk("sb_keep", rdata_o, 32'h0000007F);
    run(0, 2'b10, 0, 32'h10, 0);
    chk("lw_data", rdata_o, 32'h8001AB00);
    run(0, 2'b10, 0, 32'h6, 0);
    chk("mis_lat", lat, 1);
    chk("mis_cyc", ncyc, 0);
    chk("mis_fault", fault_o, 1);
    chk("mis_cause", fault_cause_o, 2'b01);
    run(0, 2'b11, 0, 32'h0, 0);
    chk("ill_cause", fault_cause_o, 2'b01);
    mode = 3;
    run(0, 2'b10, 0, 32'h10, 0);
    chk("err_fault", fault_o, 1);
    chk("err_cause", fault_cause_o, 2'b10);
    chk("err_rdata", rdata_o, 0);
    mode = 1;
    run(0, 2'b10, 0, 32'h10, 0);
    chk("tmo_cyc", ncyc, 8);
    chk("tmo_lat", lat, 9);
    chk("tmo_cause", fault_cause_o, 2'b11);
    mode = 2; rty_left = 4;
    run(0, 2'b10, 0, 32'h10, 0);
    chk("rty4_gaps", gaps, 3);
    chk("rty4_fault", fault_o, 1);
    chk("rty4_cause", fault_cause_o, 2'b11);
    rty_left = 3;
    run(0, 2'b10, 0, 32'h10, 0);
    chk("rty3_gaps", gaps, 3);
    chk("rty3_fault", fault_o, 0);
    chk("rty3_data", rdata_o, 32'h8001AB00);
    mode = 1;
    @(negedge clk);
    req = 1; we = 0; size = 2'b10; addr = 32'h10;
    @(negedge clk);
    req = 0;
    @(negedge clk);
    chk("mid_cyc_before", cyc_o, 1);
    rst = 1;
    #1;
    chk("mid_cyc_rst", cyc_o, 0);
    chk("mid_ready_rst", ready_o, 1);
    @(negedge clk);
    rst = 0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    chk("mid_no_done", ndone, 0);
    chk("mid_ready", ready_o, 1);
    mode = 0;
    run(0, 2'b10, 0, 32'h10, 0);
    chk("post_rst_lw", rdata_o, 32'h8001AB00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
